// File: rtl/alu_share_ctrl_pkg.sv
// Shared op codes and sequencer states for the shared-ALU controller.
package alu_share_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_XOR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_e;

endpackage

// File: rtl/alu_share_ctrl_if.sv
// Two command channels and one tagged response channel around the shared ALU.
interface alu_share_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [1:0]       req0_op;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [1:0]       req1_op;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_status;

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req1_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_status,
        output rsp_ready
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req1_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_status,
        input  rsp_ready
    );
endinterface

// File: rtl/alu_share_ctrl_alu.sv
// Combinational WIDTH-bit ALU: add/sub/and/xor, modulo 2^WIDTH.
module alu_share_ctrl_alu
    import alu_share_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_e              op,
    output logic [WIDTH-1:0] y,
    output logic             zero
);

    always_comb begin
        y = '0;
        case (op)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            OP_XOR:  y = a ^ b;
            default: y = '0;
        endcase
    end

    // Status only reports equality, so it is meaningful for sub alone.
    assign zero = (op == OP_SUB) && (y == '0);

endmodule

// File: rtl/alu_share_ctrl.sv
// Round-robin arbiter and IDLE/EXEC/RESP sequencer sharing one ALU
// between two requesters; returns a tagged, registered result.
module alu_share_ctrl
    import alu_share_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    alu_share_ctrl_if.slave bus,
    output logic           busy
);

    state_e           state_q;
    state_e           state_d;
    logic             last_grant_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    op_e              op_q;
    logic             id_q;

    logic             rsp_valid_q;
    logic             rsp_id_q;
    logic [WIDTH-1:0] rsp_result_q;
    logic             rsp_status_q;

    logic             gnt0;
    logic             gnt1;
    logic             accept;
    logic [WIDTH-1:0] alu_y;
    logic             alu_zero;

    // On a tie the requester not granted last time wins.
    assign gnt0 = bus.req0_valid &&
                  (!bus.req1_valid || last_grant_q);
    assign gnt1 = bus.req1_valid &&
                  (!bus.req0_valid || !last_grant_q);

    assign accept = (state_q == ST_IDLE) && !rst &&
                    (gnt0 || gnt1);

    assign bus.req0_ready = accept && gnt0;
    assign bus.req1_ready = accept && gnt1;

    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_status = rsp_status_q;

    assign busy = (state_q != ST_IDLE);

    alu_share_ctrl_alu #(
        .WIDTH(WIDTH)
    ) u_alu (
        .a    (a_q),
        .b    (b_q),
        .op   (op_q),
        .y    (alu_y),
        .zero (alu_zero)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: if (bus.rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= OP_ADD;
            id_q         <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_status_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                last_grant_q <= gnt1;
                id_q         <= gnt1;
                a_q          <= gnt1 ? bus.req1_a : bus.req0_a;
                b_q          <= gnt1 ? bus.req1_b : bus.req0_b;
                op_q         <= op_e'(gnt1 ? bus.req1_op
                                           : bus.req0_op);
            end
            if (state_q == ST_EXEC) begin
                rsp_valid_q  <= 1'b1;
                rsp_id_q     <= id_q;
                rsp_result_q <= alu_y;
                rsp_status_q <= alu_zero;
            end else if (state_q == ST_RESP && bus.rsp_ready) begin
                rsp_valid_q  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl: vector table, scoreboard,
// contention, backpressure and mid-transaction reset.
module tb_alu_share_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    alu_share_ctrl_if #(.WIDTH(4)) bus ();

    alu_share_ctrl #(.WIDTH(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus.slave),
        .busy (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         id;
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] op;
        logic [3:0] res;
        bit         st;
    } vec_t;

    typedef struct {
        bit         id;
        logic [3:0] res;
        bit         st;
        int         due;
    } exp_t;

    vec_t vecs [8];
    exp_t sbq [$];
    exp_t mon_e;
    bit   prev_v;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] model(input logic [3:0] a,
                                         input logic [3:0] b,
                                         input logic [1:0] op);
        logic [3:0] r;
        case (op)
            2'b00:   r = a + b;
            2'b01:   r = a - b;
            2'b10:   r = a & b;
            default: r = a ^ b;
        endcase
        return {(op == 2'b01) && (r == 4'd0), r};
    endfunction

    task automatic drive(input bit id, input bit v, input logic [3:0] a,
                         input logic [3:0] b, input logic [1:0] op);
        if (id == 1'b0) begin
            bus.req0_valid = v;
            bus.req0_a = a;
            bus.req0_b = b;
            bus.req0_op = op;
        end else begin
            bus.req1_valid = v;
            bus.req1_a = a;
            bus.req1_b = b;
            bus.req1_op = op;
        end
    endtask

    function automatic void push(input bit id, input logic [4:0] r);
        exp_t e;
        e.id = id;
        e.res = r[3:0];
        e.st = r[4];
        e.due = cyc + 2;
        sbq.push_back(e);
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input bit id, input logic [3:0] a,
                        input logic [3:0] b, input logic [1:0] op,
                        input logic [3:0] res, input bit st);
        bit ok = 1'b0;
        drive(id, 1'b1, a, b, op);
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if ((id ? bus.req1_ready : bus.req0_ready) === 1'b1) begin
                ok = 1'b1;
                push(id, {st, res});
            end
            @(posedge clk);
            #1;
        end
        drive(id, 1'b0, a, b, op);
        chk("send_accept", ok, 1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 30 && sbq.size() != 0; i++)
            @(negedge clk);
        chk("drain", sbq.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        sbq.delete();
        rst = 1'b0;
    endtask

    // Scoreboard side: latency on the rising edge of rsp_valid,
    // payload at the handshake.
    always @(negedge clk) begin
        if (rst) begin
            prev_v <= 1'b0;
        end else begin
            if (bus.rsp_valid) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_rsp", 1, 0);
                end else begin
                    if (!prev_v) chk("latency", cyc, sbq[0].due);
                    if (bus.rsp_ready) begin
                        mon_e = sbq.pop_front();
                        chk("rsp_id", bus.rsp_id, mon_e.id);
                        chk("rsp_result", bus.rsp_result, mon_e.res);
                        chk("rsp_status", bus.rsp_status, mon_e.st);
                    end
                end
            end
            prev_v <= bus.rsp_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int         g;
        bit         grants [4];
        logic [4:0] r0;
        logic [4:0] r1;
        bit         seen;

        vecs[0] = '{1'b0, 4'h5, 4'h3, 2'b00, 4'h8, 1'b0};
        vecs[1] = '{1'b1, 4'h7, 4'h7, 2'b01, 4'h0, 1'b1};
        vecs[2] = '{1'b1, 4'h4, 4'h3, 2'b10, 4'h0, 1'b0};
        vecs[3] = '{1'b0, 4'h2, 4'h3, 2'b01, 4'hF, 1'b0};
        vecs[4] = '{1'b0, 4'h9, 4'h9, 2'b00, 4'h2, 1'b0};
        vecs[5] = '{1'b1, 4'hA, 4'h5, 2'b11, 4'hF, 1'b0};
        vecs[6] = '{1'b1, 4'h8, 4'h3, 2'b01, 4'h5, 1'b0};
        vecs[7] = '{1'b0, 4'hF, 4'h1, 2'b00, 4'h0, 1'b0};

        rst = 1'b1;
        bus.rsp_ready = 1'b1;
        drive(0, 1'b1, 4'h1, 4'h1, 2'b00);
        drive(1, 1'b1, 4'h1, 4'h1, 2'b00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_id", bus.rsp_id, 0);
        chk("rst_rsp_result", bus.rsp_result, 0);
        chk("rst_rsp_status", bus.rsp_status, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready0", bus.req0_ready, 0);
        chk("rst_ready1", bus.req1_ready, 0);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 4'h0, 4'h0, 2'b00);
        drive(1, 1'b0, 4'h0, 4'h0, 2'b00);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            send(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].op,
                 vecs[i].res, vecs[i].st);
            wait_drain();
        end

        // Contention straight after reset: req0 must win first.
        do_reset();
        r0 = model(4'h1, 4'h2, 2'b00);
        r1 = model(4'h6, 4'h6, 2'b01);
        drive(0, 1'b1, 4'h1, 4'h2, 2'b00);
        drive(1, 1'b1, 4'h6, 4'h6, 2'b01);
        g = 0;
        for (int i = 0; i < 40 && g < 4; i++) begin
            @(negedge clk);
            if (bus.req0_ready && bus.req1_ready)
                chk("both_ready", 1, 0);
            else if (bus.req0_ready) begin
                grants[g] = 1'b0;
                g++;
                push(0, r0);
            end else if (bus.req1_ready) begin
                grants[g] = 1'b1;
                g++;
                push(1, r1);
            end
            @(posedge clk);
            #1;
        end
        drive(0, 1'b0, 4'h0, 4'h0, 2'b00);
        drive(1, 1'b0, 4'h0, 4'h0, 2'b00);
        chk("grant_count", g, 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("grant_%0d", i), grants[i], i % 2);
        wait_drain();

        // Backpressure: response held, no accepts while stalled.
        bus.rsp_ready = 1'b0;
        r0 = model(4'h3, 4'h4, 2'b00);
        send(0, 4'h3, 4'h4, 2'b00, r0[3:0], r0[4]);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = bus.rsp_valid;
        end
        chk("bp_rsp_seen", seen, 1);
        @(posedge clk);
        #1;
        drive(0, 1'b1, 4'h2, 4'h2, 2'b00);
        drive(1, 1'b1, 4'h5, 4'h1, 2'b01);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", bus.rsp_valid, 1);
            chk("bp_result", bus.rsp_result, 4'h7);
            chk("bp_id", bus.rsp_id, 0);
            chk("bp_busy", busy, 1);
            chk("bp_ready0", bus.req0_ready, 0);
            chk("bp_ready1", bus.req1_ready, 0);
            @(posedge clk);
            #1;
        end
        drive(0, 1'b0, 4'h0, 4'h0, 2'b00);
        drive(1, 1'b0, 4'h0, 4'h0, 2'b00);
        bus.rsp_ready = 1'b1;
        wait_drain();

        // Reset while in EXEC: command dropped, arbiter back to req0.
        r0 = model(4'h5, 4'h1, 2'b11);
        send(0, 4'h5, 4'h1, 2'b11, r0[3:0], r0[4]);
        rst = 1'b1;
        drive(0, 1'b1, 4'h2, 4'h2, 2'b00);
        drive(1, 1'b1, 4'h1, 4'h1, 2'b01);
        @(negedge clk);
        chk("rx_ready0_a", bus.req0_ready, 0);
        chk("rx_ready1_a", bus.req1_ready, 0);
        @(posedge clk);
        #1;
        sbq.delete();
        @(negedge clk);
        chk("rx_rsp_valid", bus.rsp_valid, 0);
        chk("rx_busy", busy, 0);
        chk("rx_ready0_b", bus.req0_ready, 0);
        chk("rx_ready1_b", bus.req1_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rx_grant0", bus.req0_ready, 1);
        chk("rx_grant1", bus.req1_ready, 0);
        if (bus.req0_ready) push(0, model(4'h2, 4'h2, 2'b00));
        @(posedge clk);
        #1;
        drive(0, 1'b0, 4'h0, 4'h0, 2'b00);
        drive(1, 1'b0, 4'h0, 4'h0, 2'b00);
        wait_drain();
        repeat (4) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
